// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: op encodings, frame sizes, FSM states
// and the helper that assembles the outgoing frame.
package spi_master_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_LEN = 11;
  localparam int RD_LEN    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  // The slave decodes a read from the duplicated op[1] prefix.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [1:0] op,
                                                       input logic [7:0] wdata);
    return {op[1], op[1], op[0], wdata};
  endfunction

  function automatic logic has_rd_phase(input logic [1:0] op);
    case (op)
      OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR: return 1'b0;
      default:                            return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MOSI parallel-in/serial-out and MISO serial-in/parallel-out datapath.
// MOSI comes straight off the top bit of the transmit register.
module spi_shift_reg
  import spi_master_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 capture,
  input  logic [FRAME_LEN-1:0] frame_in,
  input  logic                 miso,
  output logic                 mosi,
  output logic [RD_LEN-1:0]    rx_word
);

  logic [FRAME_LEN-1:0] tx_q, tx_d;
  logic [RD_LEN-2:0]    rx_q, rx_d;

  // The newest bit is the live MISO input, so the byte is complete on the
  // same edge that takes the eighth sample.
  assign rx_word = {rx_q, miso};
  assign mosi    = tx_q[FRAME_LEN-1];

  always_comb begin
    tx_d = tx_q;
    if (load) begin
      tx_d = frame_in;
    end else if (shift) begin
      tx_d = {tx_q[FRAME_LEN-2:0], 1'b0};
    end
    rx_d = rx_q;
    if (capture) begin
      rx_d = rx_word[RD_LEN-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for a slave RAM wrapper: shifts out an 11-bit command frame and,
// for read-data frames, waits RD_WAIT cycles then captures one byte from MISO.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] wdata,
  input  logic       MISO,
  output logic       ready,
  output logic       SS_n,
  output logic       MOSI,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       done
);

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_LEN - 1);
  localparam logic [3:0] CAP_LAST   = 4'(RD_LEN - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST   = 4'(IDLE_GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       ss_n_q, ss_n_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       rdata_valid_q, rdata_valid_d;
  logic [7:0] rdata_q, rdata_d;

  logic       load, shift, capture;
  logic [7:0] rx_word;

  spi_shift_reg u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .capture  (capture),
    .frame_in (build_frame(op, wdata)),
    .miso     (MISO),
    .mosi     (MOSI),
    .rx_word  (rx_word)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    ss_n_d        = ss_n_q;
    ready_d       = ready_q;
    done_d        = 1'b0;
    rdata_valid_d = 1'b0;
    rdata_d       = rdata_q;
    load          = 1'b0;
    shift         = 1'b0;
    capture       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && ready_q) begin
          load    = 1'b1;
          op_d    = op;
          cnt_d   = '0;
          ss_n_d  = 1'b0;
          ready_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (has_rd_phase(op_q)) begin
            state_d = (RD_WAIT == 0) ? ST_CAPTURE : ST_WAIT;
          end else begin
            ss_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        if (cnt_q == CAP_LAST) begin
          cnt_d         = '0;
          ss_n_d        = 1'b1;
          done_d        = 1'b1;
          rdata_valid_d = (op_q == OP_RD_DATA);
          rdata_d       = rx_word;
          state_d       = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ss_n_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      ss_n_q        <= 1'b1;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      ss_n_q        <= ss_n_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign ready       = ready_q;
  assign SS_n        = ss_n_q;
  assign done        = done_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three instances (RD_WAIT 0/2/3) share stimulus;
// per-cycle expected output vectors are queued per instance and compared at negedge.
module tb_spi_master_ctrl;

  localparam int N = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [7:0]       wdata;
  logic [N-1:0]     miso;
  logic [N-1:0]     ready;
  logic [N-1:0]     ss_n;
  logic [N-1:0]     mosi;
  logic [N-1:0]     rv;
  logic [N-1:0]     done;
  logic [7:0]       rdata [N];

  int               checks;
  int               failures;
  int               cyc;
  logic [12:0]      exp_q [N][$];
  logic [7:0]       last_rd [N];
  int               sc [N];
  logic [7:0]       slave_byte;

  spi_master_ctrl #(.RD_WAIT(0), .IDLE_GAP(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .wdata(wdata), .MISO(miso[0]),
    .ready(ready[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .rdata(rdata[0]),
    .rdata_valid(rv[0]), .done(done[0]));

  spi_master_ctrl #(.RD_WAIT(2), .IDLE_GAP(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .wdata(wdata), .MISO(miso[1]),
    .ready(ready[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .rdata(rdata[1]),
    .rdata_valid(rv[1]), .done(done[1]));

  spi_master_ctrl #(.RD_WAIT(3), .IDLE_GAP(3)) u2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .wdata(wdata), .MISO(miso[2]),
    .ready(ready[2]), .SS_n(ss_n[2]), .MOSI(mosi[2]), .rdata(rdata[2]),
    .rdata_valid(rv[2]), .done(done[2]));

  always #5 clk = ~clk;

  function automatic int rw_of(input int g);
    case (g)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int ig_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Vector layout: {ready, SS_n, MOSI, done, rdata_valid, rdata[7:0]}
  task automatic push_vec(input int g, input logic r, input logic s, input logic m,
                          input logic d, input logic v, input logic [7:0] b);
    exp_q[g].push_back({r, s, m, d, v, b});
  endtask

  task automatic gen_trace(input int g, input logic [1:0] o, input logic [7:0] w,
                           input logic [7:0] byt);
    logic [10:0] fr;
    fr = {o[1], o[1], o[0], w};
    for (int k = 1; k <= 11; k++) push_vec(g, 1'b0, 1'b0, fr[11-k], 1'b0, 1'b0, last_rd[g]);
    if (o != 2'b11) begin
      push_vec(g, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, last_rd[g]);
    end else begin
      for (int k = 0; k < rw_of(g) + 8; k++) push_vec(g, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_rd[g]);
      last_rd[g] = byt;
      push_vec(g, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, byt);
    end
    for (int k = 1; k < ig_of(g); k++) push_vec(g, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, last_rd[g]);
  endtask

  // One clock cycle: compare all instances at negedge, update the slave models, leave #1 after.
  task automatic cycle();
    logic [12:0] act;
    logic [12:0] e;
    int          idx;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      act = {ready[g], ss_n[g], mosi[g], done[g], rv[g], rdata[g]};
      if (exp_q[g].size() > 0) e = exp_q[g].pop_front();
      else                     e = {5'b11000, last_rd[g]};
      chk($sformatf("cyc%0d_u%0d", cyc, g), 32'(act), 32'(e));
      if (ss_n[g] == 1'b0) sc[g]++;
      else                 sc[g] = 0;
      idx = sc[g] - 12 - rw_of(g);
      miso[g] = (idx >= 0 && idx < 8) ? slave_byte[7-idx] : 1'b1;
    end
    cyc++;
    #1;
  endtask

  function automatic bit busy();
    for (int g = 0; g < N; g++) if (exp_q[g].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // mode 0: plain frame; 1: extra start pulse at T+4; 2: rst asserted at T+6.
  task automatic run_frame(input logic [1:0] o, input logic [7:0] w,
                           input logic [7:0] byt, input int mode);
    int n;
    slave_byte = byt;
    start = 1'b1;
    op    = o;
    wdata = w;
    for (int g = 0; g < N; g++) gen_trace(g, o, w, byt);
    cycle();
    start = 1'b0;
    op    = 2'($urandom);
    wdata = 8'($urandom);
    n = 1;
    while (busy()) begin
      if (mode == 1 && n == 4) begin
        start = 1'b1;
        op    = 2'b00;
        wdata = 8'h00;
      end else begin
        start = 1'b0;
      end
      if (mode == 2 && n == 6) begin
        rst = 1'b1;
        for (int g = 0; g < N; g++) begin
          exp_q[g].delete();
          last_rd[g] = 8'h00;
        end
      end
      cycle();
      n++;
      if (mode == 2 && n == 7) rst = 1'b0;
      if (n > 100) begin
        chk("frame_timeout", 32'(n), 32'd0);
        break;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    cycle();
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    start      = 1'b1;
    op         = 2'b11;
    wdata      = 8'hFF;
    miso       = '1;
    slave_byte = 8'h00;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    for (int g = 0; g < N; g++) begin
      last_rd[g] = 8'h00;
      sc[g]      = 0;
    end

    // Reset held with start asserted: reset wins, outputs stay idle.
    repeat (3) cycle();
    rst   = 1'b0;
    start = 1'b0;
    cycle();

    run_frame(2'b00, 8'hFF, 8'h00, 0);
    run_frame(2'b01, 8'h5A, 8'h00, 0);
    run_frame(2'b11, 8'h3C, 8'hA5, 0);
    run_frame(2'b10, 8'hC3, 8'h00, 1);
    run_frame(2'b01, 8'h96, 8'h00, 2);
    run_frame(2'b00, 8'h81, 8'h00, 0);
    run_frame(2'b11, 8'h0F, 8'h3C, 0);
    run_frame(2'b01, 8'h7E, 8'h00, 0);
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL provide parameter RD_WAIT, default 2, number of idle cycles between the last MOSI bit and the first MISO sample of a read-data frame (range 0..15).
REQ-002 SHALL provide parameter IDLE_GAP, default 1, minimum cycles SS_n stays high between frames (range 1..15).
REQ-003 SHALL use one clock, and reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all outputs registered on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  transaction request, honoured only while ready=1.
REQ-007 op  input  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-008 wdata  input  8  address or data payload.
REQ-009 MISO  input  1  serial data from the SPI slave RAM wrapper.
REQ-010 ready  output  1  high when a new start will be accepted.
REQ-011 SS_n  output  1  slave select, active low.
REQ-012 MOSI  output  1  serial data to slave, MSB first.
REQ-013 rdata  output  8  last byte read; holds until the next rd-data completes.
REQ-014 rdata_valid  output  1  one-cycle pulse when rdata updates.
REQ-015 done  output  1  one-cycle pulse at the end of every frame.

Function
REQ-016 States SHALL be IDLE, SHIFT, WAIT, CAPTURE, GAP; reset enters IDLE.
REQ-017 In IDLE, ready=1, SS_n=1, MOSI=0; start&ready at edge T SHALL latch op and wdata into an 11-bit frame {op[1], op[1], op[0], wdata[7:0]} and enter SHIFT.
REQ-018 SHIFT SHALL drive SS_n=0 with MOSI = frame bits 10..0 on cycles T+1..T+11, one bit per cycle, tracked by a 4-bit counter.
REQ-019 For op 00/01/10, cycle T+12 SHALL drive SS_n=1, MOSI=0, done=1, and enter GAP.
REQ-020 For op 11, SS_n SHALL stay low, MOSI=0, for RD_WAIT cycles (WAIT; skipped when RD_WAIT=0); CAPTURE then samples MISO on 8 consecutive rising edges, MSB first, into a shift register.
REQ-021 The first MISO sample SHALL be taken at the edge ending cycle T+12+RD_WAIT and the last at the edge ending cycle T+19+RD_WAIT; the following cycle drives SS_n=1, done=1, rdata_valid=1, rdata=captured byte, and enters GAP.
REQ-022 GAP SHALL hold SS_n=1, ready=0 for IDLE_GAP cycles, then return to IDLE.
REQ-023 ready SHALL be 0 in SHIFT, WAIT, CAPTURE, GAP; start while ready=0 SHALL be ignored and not queued.
REQ-024 op and wdata changes after acceptance SHALL NOT affect the frame in flight.
REQ-025 done and rdata_valid SHALL never be high for more than one consecutive cycle; rdata_valid only on op 11.
REQ-026 rst asserted mid-frame SHALL abort at the next edge: SS_n=1, MOSI=0, no done or rdata_valid pulse, state IDLE.

Reset
REQ-027 On rst: state=IDLE, SS_n=1, MOSI=0, ready=1, done=0, rdata_valid=0, rdata=8'h00, counters and shift registers cleared.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 Package spi_master_pkg SHALL hold op encodings (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA), FRAME_LEN=11, RD_LEN=8 and the state enumeration.
REQ-030 One sub-module spi_shift_reg SHALL implement the 11-bit parallel-in/serial-out MOSI path and the 8-bit serial-in/parallel-out MISO path with load, shift and capture enables; the FSM and counters remain in spi_master_ctrl.

Verification
REQ-031 Reset: hold rst 3 cycles -> SS_n=1, MOSI=0, ready=1, rdata=00, no pulses.
REQ-032 start, op=00, wdata=FF -> MOSI 0,0,0 then eight 1s on T+1..T+11 with SS_n=0, done at T+12, ready back at T+13 (IDLE_GAP=1).
REQ-033 start, op=01, wdata=5A -> MOSI 0,0,1,0,1,0,1,1,0,1,0; done once; rdata_valid stays 0.
REQ-034 start, op=11, slave model drives A5 MSB-first from cycle T+12+RD_WAIT -> rdata=A5 with rdata_valid and done pulsing together at T+20+RD_WAIT; repeat with RD_WAIT=0 and 3.
REQ-035 start pulsed again at T+4 during an op=10 frame -> ignored, frame bits unchanged, exactly one done.
REQ-036 rst asserted at T+6 of op=01 frame -> SS_n=1 next edge, no done, subsequent op=00 frame completes normally.
